full_adder: RTL and testbench

Parameterised WIDTH-bit ripple-carry adder built from 1-bit full-adder cells. It provides a combinational sum/carry path and a registered copy of the result with a signed-overflow flag. It is the basic arithmetic leaf used by wider datapath blocks. With WIDTH=1 it is a plain full adder: {Cout,Sum} = In1 + In2 + Cin.

---
 rtl/full_adder.sv | 49 ++++
 tb/tb_full_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from 1-bit full-adder cells, with a
// registered copy of the result and a signed-overflow flag.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Cin,
    input  logic             En,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] SumQ,
    output logic             CoutQ,
    output logic             OvfQ
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p      = In1[i] ^ In2[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (In1[i] & In2[i]) | (c[i] & p);
    end

    assign Sum  = s;
    assign Cout = c[WIDTH];
    // For WIDTH=1, c[WIDTH-1] is Cin, so this reduces to Cout ^ Cin.
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SumQ  <= '0;
            CoutQ <= 1'b0;
            OvfQ  <= 1'b0;
        end else if (En) begin
            SumQ  <= Sum;
            CoutQ <= Cout;
            OvfQ  <= ovf;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 truth table and WIDTH=8
// registered path checked through an expected-value queue.
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, cin1, en1;
    logic       sum1, cout1, sumq1, coutq1, ovfq1;

    logic [7:0] a8, b8;
    logic       cin8, en8;
    logic [7:0] sum8, sumq8;
    logic       cout8, coutq8, ovfq8;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [9:0] sb8[$];
    logic [1:0] tbl1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .In1   (a1),
        .In2   (b1),
        .Cin   (cin1),
        .En    (en1),
        .Sum   (sum1),
        .Cout  (cout1),
        .SumQ  (sumq1),
        .CoutQ (coutq1),
        .OvfQ  (ovfq1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .In1   (a8),
        .In2   (b8),
        .Cin   (cin8),
        .En    (en8),
        .Sum   (sum8),
        .Cout  (cout8),
        .SumQ  (sumq8),
        .CoutQ (coutq8),
        .OvfQ  (ovfq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}; overflow from the operand/result sign rule.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v = (a[7] == b[7]) && (t[7] != a[7]);
        return {v, t};
    endfunction

    task automatic cycle8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic en);
        logic [9:0] exp;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; en8 = en;
        #1;
        exp = model8(a, b, c);
        check("comb8", 16'({cout8, sum8}), 16'(exp[8:0]));
        if (en) sb8.push_back(exp);
        @(posedge clk);
        #1;
        if (sb8.size() != 0) begin
            exp = sb8.pop_front();
            check("reg8", 16'({ovfq8, coutq8, sumq8}), 16'(exp));
        end
    endtask

    initial begin
        logic [9:0] e;
        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; en1 = 0;
        a8 = 0; b8 = 0; cin8 = 0; en8 = 0;
        #1;
        check("reset_w1", 16'({ovfq1, coutq1, sumq1}), 16'd0);
        check("reset_w8", 16'({ovfq8, coutq8, sumq8}), 16'd0);

        // WIDTH=1 truth table, combinational, valid during reset.
        for (int k = 0; k < 8; k++) begin
            {a1, b1, cin1} = 3'(k);
            #1;
            check($sformatf("tt1_%0d", k), 16'({cout1, sum1}), 16'(tbl1[k]));
            #19;
        end

        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 registered path including the Cout^Cin overflow.
        @(negedge clk);
        {a1, b1, cin1} = 3'b111; en1 = 1'b1;
        @(posedge clk); #1;
        check("reg1_111", 16'({ovfq1, coutq1, sumq1}), 16'b011);
        @(negedge clk);
        {a1, b1, cin1} = 3'b001;
        @(posedge clk); #1;
        check("reg1_001", 16'({ovfq1, coutq1, sumq1}), 16'b101);
        @(negedge clk);
        en1 = 1'b0;

        // WIDTH=8 directed cases.
        cycle8(8'hFF, 8'h01, 1'b0, 1'b1);
        check("ff01_cout", 16'(coutq8), 16'd1);
        check("ff01_ovf", 16'(ovfq8), 16'd0);
        cycle8(8'h7F, 8'h00, 1'b1, 1'b1);
        check("7f_ovf", 16'(ovfq8), 16'd1);
        check("7f_sum", 16'(sumq8), 16'h80);
        cycle8(8'h80, 8'h80, 1'b0, 1'b1);

        // Hold with En=0 while the combinational sum tracks new operands.
        cycle8(8'h12, 8'h34, 1'b0, 1'b1);
        check("cap_46", 16'(sumq8), 16'h46);
        for (int k = 0; k < 3; k++) begin
            cycle8(8'(8'hA0 + k), 8'(8'h31 * k), 1'(k), 1'b0);
            check($sformatf("hold_%0d", k), 16'(sumq8), 16'h46);
        end

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 16'({ovfq8, coutq8, sumq8}), 16'd0);
        e = model8(a8, b8, cin8);
        check("live_in_rst", 16'({cout8, sum8}), 16'(e[8:0]));

        // Reset wins over a simultaneous En capture.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        check("rst_wins", 16'({ovfq8, coutq8, sumq8}), 16'd0);

        // Release with En=0: no capture yet.
        @(negedge clk);
        rst_n = 1'b1; en8 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_hold", 16'({ovfq8, coutq8, sumq8}), 16'd0);
        cycle8(8'h55, 8'h66, 1'b1, 1'b1);

        // Random operands, one per cycle.
        for (int k = 0; k < 1000; k++) begin
            cycle8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        check("sb_empty", 16'(sb8.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
